// File: rtl/stream_arb_pkg.sv
// Shared types and default sizing for the round-robin stream arbiter.
package stream_arb_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/stream_arb_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module stream_arb_rr_pick #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr_i,
    output logic [NUM_PORTS-1:0]         gnt_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 stream arbiter with bounded bursts and a registered output stage.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_PORTS)-1:0]    out_src,
    output logic [NUM_PORTS-1:0]            grant
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]           gidx_q, gidx_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           burst_q, burst_d;
    logic                       ovld_q, ovld_d;
    logic [DATA_WIDTH-1:0]      odata_q, odata_d;
    logic [IDX_W-1:0]           osrc_q, osrc_d;

    logic [NUM_PORTS-1:0]                 pick_gnt;
    logic [IDX_W-1:0]                     pick_idx;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data_arr;
    logic                                 can_load;
    logic                                 xfer;

    stream_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i (in_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign in_data_arr = in_data;
    assign can_load    = !ovld_q || out_ready;
    assign in_ready    = (state_q == BUSY && can_load) ? grant_q : '0;
    assign xfer        = |(in_valid & in_ready);

    assign grant     = grant_q;
    assign out_valid = ovld_q;
    assign out_data  = odata_q;
    assign out_src   = osrc_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        unique case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    state_d  = BUSY;
                    grant_d  = pick_gnt;
                    gidx_d   = pick_idx;
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
                    burst_d  = '0;
                end
            end
            BUSY: begin
                // Release always lands in IDLE, so a new grant never follows in the same edge.
                if ((xfer && burst_q == CNT_W'(MAX_BURST - 1)) || (!xfer && !in_valid[gidx_q])) begin
                    state_d = IDLE;
                    grant_d = '0;
                    burst_d = '0;
                end else if (xfer) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovld_d  = ovld_q;
        odata_d = odata_q;
        osrc_d  = osrc_q;
        if (xfer) begin
            ovld_d  = 1'b1;
            odata_d = in_data_arr[gidx_q];
            osrc_d  = gidx_q;
        end else if (out_ready) begin
            ovld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            ovld_q   <= 1'b0;
            odata_q  <= '0;
            osrc_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            ovld_q   <= ovld_d;
            odata_q  <= odata_d;
            osrc_q   <= osrc_d;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (4 ports, 8-bit data, bursts of 4).
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [3:0]  grant;

    int checks   = 0;
    int failures = 0;

    stream_rr_arbiter #(
        .NUM_PORTS  (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  rdy;   // in_ready before the edge
        logic [3:0]  gnt;   // after the edge
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  src;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g, input logic ov,
                           input logic [7:0] od, input logic [1:0] src);
        chk({nm, ".grant"}, 32'(grant), 32'(g));
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, ".out_data"}, 32'(out_data), 32'(od));
        chk({nm, ".out_src"}, 32'(out_src), 32'(src));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] oh(input int p);
        logic [3:0] v;
        v = 4'b0001 << p;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int p;
        //          vld      dat           ordy  rdy      gnt      ov    od     src
        tbl[0]  = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[2]  = '{4'b0000, 32'h00A5_0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[3]  = '{4'b0000, 32'h00A5_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[4]  = '{4'b1000, 32'h3300_0000, 1'b1, 4'b0000, 4'b1000, 1'b0, 8'hA5, 2'd2};
        tbl[5]  = '{4'b1000, 32'h3300_0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'h33, 2'd3};
        tbl[6]  = '{4'b0000, 32'h3300_0000, 1'b1, 4'b1000, 4'b0000, 1'b0, 8'h33, 2'd3};
        tbl[7]  = '{4'b1001, 32'h3300_0010, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'h33, 2'd3};
        tbl[8]  = '{4'b1001, 32'h3300_0010, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[9]  = '{4'b1001, 32'h3300_0010, 1'b0, 4'b0000, 4'b0001, 1'b1, 8'h10, 2'd0};
        tbl[10] = '{4'b0000, 32'h3300_0010, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'h10, 2'd0};

        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        tick();
        chk_out("reset", 4'b0000, 1'b0, 8'h00, 2'd0);
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        do_reset();

        // single requester, pointer wrap 3 -> 0, output stall
        for (int i = 0; i < 11; i++) begin
            in_valid  = tbl[i].vld;
            in_data   = tbl[i].dat;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            tick();
            chk_out($sformatf("row%0d", i), tbl[i].gnt, tbl[i].ov, tbl[i].od, tbl[i].src);
        end

        // all ports valid: 4-beat bursts in order 0,1,2,3,0 with one idle cycle between
        do_reset();
        in_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            p = g % 4;
            tick();
            chk($sformatf("rr%0d.grant", g), 32'(grant), 32'(oh(p)));
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(i * 16 + b);
                in_data = d;
                #1;
                chk($sformatf("rr%0d.%0d.in_ready", g, b), 32'(in_ready), 32'(oh(p)));
                tick();
                chk($sformatf("rr%0d.%0d.out_valid", g, b), 32'(out_valid), 32'h1);
                chk($sformatf("rr%0d.%0d.out_src", g, b), 32'(out_src), 32'(p));
                chk($sformatf("rr%0d.%0d.out_data", g, b), 32'(out_data), 32'(p * 16 + b));
            end
            chk($sformatf("rr%0d.release", g), 32'(grant), 32'h0);
        end

        // out_ready low for 5 cycles: held beat stays put, then drains without loss
        do_reset();
        in_valid = 4'b0010;
        in_data  = 32'h0000_5A00;
        tick();
        chk("stall.grant", 32'(grant), 32'h2);
        tick();
        chk_out("stall.first", 4'b0010, 1'b1, 8'h5A, 2'd1);
        out_ready = 1'b0;
        in_data   = 32'h0000_7700;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'h0);
            tick();
            chk_out($sformatf("stall%0d", c), 4'b0010, 1'b1, 8'h5A, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.resume.in_ready", 32'(in_ready), 32'h2);
        tick();
        chk_out("stall.resume", 4'b0010, 1'b1, 8'h77, 2'd1);
        in_valid = 4'b0000;
        tick();
        chk_out("stall.drain", 4'b0000, 1'b0, 8'h77, 2'd1);

        // port 1 drops after 2 beats; port 2 next, with a full fresh burst
        do_reset();
        in_valid = 4'b0110;
        in_data  = 32'h0022_1100;
        tick();
        chk("drop.grant1", 32'(grant), 32'h2);
        tick();
        tick();
        chk_out("drop.beat2", 4'b0010, 1'b1, 8'h11, 2'd1);
        in_valid = 4'b0100;
        tick();
        chk("drop.release", 32'(grant), 32'h0);
        in_valid = 4'b0110;
        tick();
        chk("drop.grant2", 32'(grant), 32'h4);
        for (int b = 0; b < 4; b++) begin
            in_data = {8'h00, 8'(8'h20 + b), 8'h11, 8'h00};
            tick();
            chk_out($sformatf("drop.p2b%0d", b), (b < 3) ? 4'b0100 : 4'b0000, 1'b1,
                    8'(8'h20 + b), 2'd2);
        end

        // asynchronous reset mid-burst, then lowest valid port wins
        do_reset();
        in_valid = 4'b0010;
        in_data  = 32'h0000_9900;
        tick();
        tick();
        chk_out("arst.pre", 4'b0010, 1'b1, 8'h99, 2'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_out("arst.now", 4'b0000, 1'b0, 8'h00, 2'd0);
        chk("arst.in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        in_valid = 4'b0101;
        in_data  = 32'h0044_0055;
        tick();
        chk("arst.grant", 32'(grant), 32'h1);
        tick();
        chk_out("arst.beat", 4'b0001, 1'b1, 8'h55, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of requesting streams (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the stream payload.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum number of beats per grant (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, NUM_PORTS bits: valid for each requester i.
REQ-007 The block SHALL have port in_ready, output, NUM_PORTS bits: ready for each requester i.
REQ-008 The block SHALL have port in_data, input, NUM_PORTS*DATA_WIDTH bits: payload; requester i SHALL occupy bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port out_valid, output, 1 bit: valid towards the shared datapath.
REQ-010 The block SHALL have port out_ready, input, 1 bit: ready from the shared datapath.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: registered payload.
REQ-012 The block SHALL have port out_src, output, $clog2(NUM_PORTS) bits: index of the requester that supplied out_data.
REQ-013 The block SHALL have port grant, output, NUM_PORTS bits: one-hot current grant, all-zero when idle.

Function
REQ-014 The block SHALL implement FSM states IDLE (no grant) and BUSY (one grant held).
REQ-015 In IDLE with any in_valid bit high, the block SHALL choose the first requester at or after rr_ptr (wrapping modulo NUM_PORTS), register its one-hot grant, and enter BUSY on the next edge.
REQ-016 On each new grant, rr_ptr SHALL be set to (granted index + 1) mod NUM_PORTS.
REQ-017 In IDLE with no in_valid bit high, the block SHALL remain in IDLE with grant all-zero.
REQ-018 in_ready[i] SHALL equal grant[i] AND state==BUSY AND (!out_valid OR out_ready), combinationally.
REQ-019 A transfer SHALL occur on a cycle where in_valid[i] and in_ready[i] are both high.
REQ-020 On a transfer, out_data and out_src SHALL load on the next edge and out_valid SHALL be 1, giving a latency of 1 cycle.
REQ-021 out_valid SHALL clear when out_ready is high with no concurrent transfer.
REQ-022 While out_valid is high and out_ready is low, out_data and out_src SHALL remain stable.
REQ-023 burst_cnt SHALL increment on each transfer in BUSY and SHALL reset to 0 when the grant is released.
REQ-024 BUSY SHALL return to IDLE, clearing grant, after the transfer that makes burst_cnt reach MAX_BURST.
REQ-025 BUSY SHALL also return to IDLE on any cycle where the granted in_valid is low.
REQ-026 Release and new arbitration SHALL never coincide; exactly one IDLE cycle SHALL separate consecutive grants.
REQ-027 in_valid bits of non-granted requesters SHALL have no effect while in BUSY.

Reset
REQ-028 While rst is high, the block SHALL force state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, out_valid=0, out_data=0, out_src=0, and in_ready=0, immediately and regardless of clk.
REQ-029 Reset asserted mid-burst SHALL drop the in-flight beat held in the output register; no partial state SHALL survive.
REQ-030 After reset, the first grant SHALL go to the lowest-indexed requester that is valid.

Structure
REQ-031 Package stream_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the default parameter constants.
REQ-032 The round-robin selection SHALL live in one combinational sub-module, stream_arb_rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index).
REQ-033 The top level SHALL contain the FSM, rr_ptr, burst_cnt and the output register.

Verification
REQ-034 Requester 2 alone sends 0xA5 with out_ready=1 -> grant=0b0100 one cycle after in_valid; out_data=0xA5 and out_src=2 one cycle after the handshake.
REQ-035 All 4 requesters continuously valid, MAX_BURST=4, out_ready=1 -> 4 beats each in port order 0,1,2,3,0..., with exactly one idle cycle between grants.
REQ-036 out_ready held low for 5 cycles with out_valid=1 -> out_data stable, in_ready all zero; the held beat is delivered when out_ready rises, with no loss and no duplication.
REQ-037 Port 1 drops in_valid after 2 beats -> grant released next edge; next grant goes to port 2 if valid, and burst_cnt restarts from 0.
REQ-038 Last grant to port 3, then ports 0 and 3 request -> port 0 is granted (pointer wrap).
REQ-039 rst pulsed mid-burst (asynchronous to clk) -> all outputs zero immediately; after release, ports 0 and 2 valid -> port 0 granted first.
